pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the basic control path. Owns the architectural PC, issues one instruction-memory request at a time, and hands each fetched word to decode with a valid/ready handshake. Consumes the next-PC selection (`pcsrc`, `pc_target`) from execute. It is the sequential end of the next-PC path whose combinational selection is done by `pc_mux`.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `pcsrc`  in  1  — one-cycle redirect pulse from execute (branch taken or jump).
- `pc_target`  in  32  — redirect address, valid when `pcsrc`=1. Bits [1:0] are ignored and forced to 0.
- `imem_req_valid`  out  1  — fetch request valid.
- `imem_req_addr`  out  32  — fetch address; equal to `pc`.
- `imem_req_ready`  in  1  — memory accepts the request.
- `imem_rsp_valid`  in  1  — response valid; arrives ≥1 cycle after the accepting handshake.
- `imem_rsp_data`  in  32  — instruction word.
- `if_valid`  out  1  — fetched instruction available to decode.
- `if_instr`  out  32  — instruction word.
- `if_pc`  out  32  — address of `if_instr`.
- `if_pc_plus4`  out  32  — `if_pc + 4`, mod 2^32.
- `if_ready`  in  1  — decode accepts.
- `pc`  out  32  — current PC register.

## Operation

- States:
  - IDLE: reset state only.
  - FETCH: `imem_req_valid`=1.
  - WAIT: request accepted, awaiting response.
  - HOLD: `if_valid`=1, waiting for decode.
- Transitions:
  - IDLE→FETCH: unconditionally, on the first edge after reset release.
  - FETCH→WAIT: on `imem_req_valid && imem_req_ready`.
  - WAIT→HOLD: on `imem_rsp_valid` with kill=0. Captures `if_instr`=`rsp_data`, `if_pc`=`pc`. Sets `pc`←`pc+4`.
  - WAIT→FETCH: on `imem_rsp_valid` with kill=1. The response is dropped and kill is cleared.
  - HOLD→FETCH: on `if_valid && if_ready`.
- Redirect (`pcsrc`=1) by state. In every case `pc`←{`pc_target`[31:2],2'b00}.
  - FETCH, no handshake: the request address changes on the next cycle. The request stays valid; memory samples the address only at the handshake.
  - FETCH with simultaneous handshake: go to WAIT with kill=1. The old-address response is discarded.
  - WAIT: set kill=1. If `imem_rsp_valid` arrives in the same cycle, that response is dropped and the block goes directly to FETCH.
  - HOLD: the buffered instruction is discarded, `if_valid`←0, and the block goes to FETCH. If `if_ready` is also 1, the transfer counts as completed; PC still takes the target.
- `imem_rsp_valid` outside WAIT is ignored.
- `pcsrc` in IDLE is ignored.
- `pc+4` wraps: `32'hFFFF_FFFC` → `32'h0000_0000`.
- Next-PC selection is `pcsrc ? target : pc_plus4` via `pc_mux`. It is applied only on response capture or redirect; otherwise `pc` holds.

## Timing

- Reset values:
  - state IDLE, `pc`=`RESET_PC`, kill=0.
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=4.
- All outputs are registered, or decoded from registered state only. There is no combinational path from any input to any output.
- First request: `imem_req_valid`=1 in the first cycle after the first post-reset edge.
- Best-case throughput: one instruction per 3 cycles (FETCH handshake, 1-cycle response, HOLD accepted immediately).
- Redirect latency: `imem_req_addr`=target in the cycle after `pcsrc`.
- Maximum outstanding requests: 1.
- `rst_n` asserted mid-transaction: immediate return to the reset values. Any in-flight response is the memory's responsibility to squash.

## Structure

- Shared package `pc_fetch_pkg`:
  - state enum {IDLE, FETCH, WAIT, HOLD};
  - `INSTR_BYTES`=4;
  - `PC_ALIGN_MASK`=`32'hFFFF_FFFC`.
- One sub-module: the existing `pc_mux`, instantiated for next-PC selection.
- Everything else is a single FSM plus registers.

## Test plan

- Reset with `RESET_PC`=`32'h100`, memory always ready with 1-cycle latency, decode always ready → requests at `0x100`, `0x104`, `0x108`. `if_pc`/`if_pc_plus4` match each request, one instruction every 3 cycles.
- `pcsrc`=1, `pc_target`=`32'h0000_0028` while in WAIT for `0x14` → `0x14` response dropped, `if_valid` stays 0, next request address is `0x28`.
- `pcsrc` with `pc_target`=`32'h0000_00F3` coincident with the FETCH handshake → request issued at `0xF0`. Response to the old address is discarded; the `0xF0` word appears with `if_pc`=`0xF0`.
- Decode holds `if_ready`=0 for 5 cycles → `if_valid`, `if_instr`, `if_pc` stable, `imem_req_valid`=0. Accept releases FETCH at `pc+4`.
- `pc`=`32'hFFFF_FFFC`, fetch completes → `if_pc_plus4`=0 and the next request address is `0x0`.
- Assert `rst_n` low while in WAIT → all outputs return to reset values immediately. A later `imem_rsp_valid` in IDLE/FETCH is ignored.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch path.
// Contents: fetch FSM state enum, instruction size, PC alignment mask,
// and a helper that forces a redirect target onto a word boundary.
package pc_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // Redirect targets carry no meaningful low bits; clear them.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_mux.sv
// Next-PC selector: sequential PC or the (already aligned) redirect target.
// Ports:
//   sel_i       - 1 selects target_i (redirect), 0 selects pc_plus4_i
//   pc_plus4_i  - sequential next PC
//   target_i    - redirect address
//   pc_next_o   - selected next PC (combinational)
module pc_mux
  import pc_fetch_pkg::*;
(
  input  logic            sel_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_next_o
);

  assign pc_next_o = sel_i ? target_i : pc_plus4_i;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   pcsrc, pc_target                - redirect pulse and address from execute
//   imem_req_valid/addr/ready       - fetch request handshake (addr == pc)
//   imem_rsp_valid/data             - fetch response
//   if_valid/instr/pc/pc_plus4      - fetched instruction to decode
//   if_ready                        - decode accepts
//   pc                              - architectural PC
// All outputs come from registers or are decoded from registered state.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcsrc,
  input  logic [31:0] pc_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        if_ready,
  output logic [31:0] pc
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_HOLD  = HOLD;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;

  logic [31:0] pc_plus4_c;
  logic [31:0] target_c;
  logic [31:0] pc_next_c;

  assign pc_plus4_c = pc_q + 32'(INSTR_BYTES);
  assign target_c   = align_pc(pc_target);

  // Next-PC selection; only consumed on capture or redirect.
  pc_mux u_pc_mux (
    .sel_i      (pcsrc),
    .pc_plus4_i (pc_plus4_c),
    .target_i   (target_c),
    .pc_next_o  (pc_next_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // Redirect on the accepting edge: the in-flight word is stale.
          kill_d  = pcsrc;
        end
        if (pcsrc) begin
          pc_d = pc_next_c;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || pcsrc) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_HOLD;
            instr_d = imem_rsp_data;
            ipc_d   = pc_q;
          end
          // A dropped stale word leaves pc alone unless a new redirect lands.
          if (pcsrc || !kill_q) begin
            pc_d = pc_next_c;
          end
        end else if (pcsrc) begin
          kill_d = 1'b1;
          pc_d   = pc_next_c;
        end
      end
      S_HOLD: begin
        if (pcsrc) begin
          state_d = S_FETCH;
          pc_d    = pc_next_c;
        end else if (if_ready) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req_valid = (state_q == S_FETCH);
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign if_valid       = (state_q == S_HOLD);
  assign if_instr       = instr_q;
  assign if_pc          = ipc_q;
  assign if_pc_plus4    = ipc_q + 32'(INSTR_BYTES);

endmodule
